// File: rtl/mem_port_arbiter.sv
// Shares the data-memory port: scalar MEM stage (same-cycle access) vs vector lane bursts.
// Round-robin in IDLE; a burst holds the port LANES cycles plus an ACK cycle that favours scalar.
module mem_port_arbiter #(
   parameter int LANES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               s_req,
   input  logic               s_we,
   input  logic [31:0]        s_addr,
   input  logic [31:0]        s_wdata,
   output logic [31:0]        s_rdata,
   output logic               stall_m,
   input  logic               v_req,
   input  logic               v_we,
   input  logic [31:0]        v_base,
   input  logic [LANES*32-1:0] v_wdata,
   output logic [LANES*32-1:0] v_rdata,
   output logic               v_ack,
   output logic               mem_we,
   output logic [31:0]        mem_addr,
   output logic [31:0]        mem_wdata,
   input  logic [31:0]        mem_rdata
);
   localparam int CW = $clog2(LANES) + 1;
   localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

   typedef enum logic [1:0] {IDLE, BURST, ACK} state_t;

   state_t        state;
   logic [CW-1:0] lane_cnt;
   logic          last_vec;
   logic          s_gnt;
   logic          v_gnt;
   logic [CW-1:0] lane;
   logic [31:0]   lane_wdata;

   // Nothing is granted while reset is held, so a stalled scalar stays frozen.
   always_comb begin
      s_gnt = 1'b0;
      v_gnt = 1'b0;
      lane  = '0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (v_req && (!s_req || !last_vec))
                  v_gnt = 1'b1;
               else if (s_req)
                  s_gnt = 1'b1;
            end
            BURST: begin
               v_gnt = 1'b1;
               lane  = lane_cnt;
            end
            ACK:     s_gnt = s_req;
            default: ;
         endcase
      end
   end

   always_comb begin
      lane_wdata = '0;
      for (int i = 0; i < LANES; i++)
         if (lane == CW'(i))
            lane_wdata = v_wdata[32*i +: 32];
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      s_rdata   = '0;
      if (v_gnt) begin
         mem_we    = v_we;
         mem_addr  = v_base + 32'({lane, 2'b00});
         mem_wdata = lane_wdata;
      end else if (s_gnt) begin
         mem_we    = s_we;
         mem_addr  = s_addr;
         mem_wdata = s_wdata;
         s_rdata   = mem_rdata;
      end
   end

   assign stall_m = s_req && !s_gnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         lane_cnt <= '0;
         last_vec <= 1'b0;
         v_rdata  <= '0;
         v_ack    <= 1'b0;
      end else begin
         v_ack <= 1'b0;
         if (s_gnt)
            last_vec <= 1'b0;
         for (int i = 0; i < LANES; i++)
            if (v_gnt && !v_we && lane == CW'(i))
               v_rdata[32*i +: 32] <= mem_rdata;
         case (state)
            IDLE: begin
               if (v_gnt) begin
                  last_vec <= 1'b1;
                  lane_cnt <= CW'(1);
                  if (LANES == 1) begin
                     state <= ACK;
                     v_ack <= 1'b1;
                  end else begin
                     state <= BURST;
                  end
               end
            end
            BURST: begin
               lane_cnt <= lane_cnt + CW'(1);
               if (lane_cnt == LAST_LANE) begin
                  state <= ACK;
                  v_ack <= 1'b1;
               end
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
